// File: rtl/featuremap_pkg.sv
// Shared types and constants for the featuremap producer/consumer blocks.
package featuremap_pkg;

  localparam int unsigned NUM_CHANNELS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/pad_position_counter.sv
// Row/column raster counter over the zero-padded (WIDTH+2)x(HEIGHT+2) frame.
module pad_position_counter #(
  parameter int unsigned WIDTH  = 112,
  parameter int unsigned HEIGHT = 112,
  localparam int unsigned RowW  = $clog2(HEIGHT + 2),
  localparam int unsigned ColW  = $clog2(WIDTH + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic is_pad,
  output logic is_last
);

  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT + 1);
  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH + 1);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance) begin
      if (is_last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == ColLast) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign is_pad  = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);
  assign is_last = (row_q == RowLast) && (col_q == ColLast);

endmodule

// File: rtl/featuremap_pad_writer_8ch.sv
// Writes an unpadded 8-channel raster into the conv2D input FIFOs with a one-pixel
// zero border, stalling upstream on any FIFO full.
module featuremap_pad_writer_8ch
  import featuremap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 112,
  parameter int unsigned HEIGHT     = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in_channel0,
  input  logic [DATA_WIDTH-1:0] data_in_channel1,
  input  logic [DATA_WIDTH-1:0] data_in_channel2,
  input  logic [DATA_WIDTH-1:0] data_in_channel3,
  input  logic [DATA_WIDTH-1:0] data_in_channel4,
  input  logic [DATA_WIDTH-1:0] data_in_channel5,
  input  logic [DATA_WIDTH-1:0] data_in_channel6,
  input  logic [DATA_WIDTH-1:0] data_in_channel7,
  output logic                  ready_out,
  input  logic                  data_fifo_full0,
  input  logic                  data_fifo_full1,
  input  logic                  data_fifo_full2,
  input  logic                  data_fifo_full3,
  input  logic                  data_fifo_full4,
  input  logic                  data_fifo_full5,
  input  logic                  data_fifo_full6,
  input  logic                  data_fifo_full7,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out_channel0,
  output logic [DATA_WIDTH-1:0] data_out_channel1,
  output logic [DATA_WIDTH-1:0] data_out_channel2,
  output logic [DATA_WIDTH-1:0] data_out_channel3,
  output logic [DATA_WIDTH-1:0] data_out_channel4,
  output logic [DATA_WIDTH-1:0] data_out_channel5,
  output logic [DATA_WIDTH-1:0] data_out_channel6,
  output logic [DATA_WIDTH-1:0] data_out_channel7,
  output logic                  frame_done
);

  state_e state_q, state_d;
  logic   frame_done_q;
  logic   any_full;
  logic   is_pad;
  logic   is_last;

  logic [DATA_WIDTH-1:0] din  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] dout [NUM_CHANNELS];

  assign din[0] = data_in_channel0;
  assign din[1] = data_in_channel1;
  assign din[2] = data_in_channel2;
  assign din[3] = data_in_channel3;
  assign din[4] = data_in_channel4;
  assign din[5] = data_in_channel5;
  assign din[6] = data_in_channel6;
  assign din[7] = data_in_channel7;

  assign data_out_channel0 = dout[0];
  assign data_out_channel1 = dout[1];
  assign data_out_channel2 = dout[2];
  assign data_out_channel3 = dout[3];
  assign data_out_channel4 = dout[4];
  assign data_out_channel5 = dout[5];
  assign data_out_channel6 = dout[6];
  assign data_out_channel7 = dout[7];

  assign any_full = data_fifo_full0 | data_fifo_full1 | data_fifo_full2 | data_fifo_full3 |
                    data_fifo_full4 | data_fifo_full5 | data_fifo_full6 | data_fifo_full7;

  // Counters only move on an actual FIFO write, so stalls and bubbles hold position.
  pad_position_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .advance (wrreq),
    .is_pad  (is_pad),
    .is_last (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_d == StDone);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_in) state_d = StRun;
      StRun:   if (wrreq && is_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wrreq     = 1'b0;
    ready_out = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      dout[c] = '0;
    end
    if (state_q == StRun) begin
      if (is_pad) begin
        // Border words are +0.0 and need nothing from upstream.
        wrreq = ~any_full;
      end else begin
        ready_out = ~any_full;
        wrreq     = valid_in & ~any_full;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          dout[c] = din[c];
        end
      end
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_featuremap_pad_writer_8ch.sv
// Directed bench: a 4x3 instance for frame/stall/reset corner cases, a 112x112 instance for bulk.
module tb_featuremap_pad_writer_8ch;

  localparam int W = 4;
  localparam int H = 3;
  localparam int FRAME = (W + 2) * (H + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  full = 8'h00;
  logic [31:0] din  [8];
  logic [31:0] dout [8];
  logic        wrreq, ready, fd;

  // Default-size instance
  logic        b_rst = 1'b1;
  logic        b_valid = 1'b0;
  logic [7:0]  b_full = 8'h00;
  logic [31:0] b_din  [8];
  logic [31:0] b_dout [8];
  logic        b_wr, b_rdy, b_fd;

  featuremap_pad_writer_8ch #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .valid_in(valid),
    .data_in_channel0(din[0]), .data_in_channel1(din[1]), .data_in_channel2(din[2]),
    .data_in_channel3(din[3]), .data_in_channel4(din[4]), .data_in_channel5(din[5]),
    .data_in_channel6(din[6]), .data_in_channel7(din[7]),
    .ready_out(ready),
    .data_fifo_full0(full[0]), .data_fifo_full1(full[1]), .data_fifo_full2(full[2]),
    .data_fifo_full3(full[3]), .data_fifo_full4(full[4]), .data_fifo_full5(full[5]),
    .data_fifo_full6(full[6]), .data_fifo_full7(full[7]),
    .wrreq(wrreq),
    .data_out_channel0(dout[0]), .data_out_channel1(dout[1]), .data_out_channel2(dout[2]),
    .data_out_channel3(dout[3]), .data_out_channel4(dout[4]), .data_out_channel5(dout[5]),
    .data_out_channel6(dout[6]), .data_out_channel7(dout[7]),
    .frame_done(fd)
  );

  featuremap_pad_writer_8ch dut_big (
    .clk(clk), .rst(b_rst), .valid_in(b_valid),
    .data_in_channel0(b_din[0]), .data_in_channel1(b_din[1]), .data_in_channel2(b_din[2]),
    .data_in_channel3(b_din[3]), .data_in_channel4(b_din[4]), .data_in_channel5(b_din[5]),
    .data_in_channel6(b_din[6]), .data_in_channel7(b_din[7]),
    .ready_out(b_rdy),
    .data_fifo_full0(b_full[0]), .data_fifo_full1(b_full[1]), .data_fifo_full2(b_full[2]),
    .data_fifo_full3(b_full[3]), .data_fifo_full4(b_full[4]), .data_fifo_full5(b_full[5]),
    .data_fifo_full6(b_full[6]), .data_fifo_full7(b_full[7]),
    .wrreq(b_wr),
    .data_out_channel0(b_dout[0]), .data_out_channel1(b_dout[1]), .data_out_channel2(b_dout[2]),
    .data_out_channel3(b_dout[3]), .data_out_channel4(b_dout[4]), .data_out_channel5(b_dout[5]),
    .data_out_channel6(b_dout[6]), .data_out_channel7(b_dout[7]),
    .frame_done(b_fd)
  );

  typedef struct {
    logic        v;
    logic [7:0]  f;
    logic        e_wr;
    logic        e_rdy;
    logic        e_fd;
    logic [31:0] e_d0;
  } vec_t;

  vec_t tbl [15];

  int tests = 0;
  int fails = 0;
  int wcnt = 0;       // padded position of next expected write in the current frame
  int acc = 0;        // upstream pixels accepted in the current frame
  int wr_cnt, rdy_cnt, fd_cnt, last_writes, first_wr, last_wr, cyc;
  logic s_wr, s_rdy, s_fd;
  logic [31:0] wlog [FRAME];

  function automatic logic [31:0] pix(input int k, input int c);
    logic [31:0] r;
    r = {8'(c + 1), 24'(k + 1)};
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int p, input int c, input int w, input int h);
    int row, col;
    row = p / (w + 2);
    col = p % (w + 2);
    if (row == 0 || row == h + 1 || col == 0 || col == w + 1) return 32'h0;
    return pix((row - 1) * w + (col - 1), c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One clock of the small instance: drive after the edge, sample and score at negedge.
  task automatic tick(input logic v, input logic [7:0] f, input logic r);
    int bad;
    @(posedge clk);
    #1;
    rst = r;
    valid = v;
    full = f;
    for (int c = 0; c < 8; c++) din[c] = pix(acc, c);
    @(negedge clk);
    s_wr = wrreq;
    s_rdy = ready;
    s_fd = fd;
    if (r) begin
      wcnt = 0;
      acc = 0;
    end else begin
      if (f != 8'h00) check("no_write_while_full", {31'b0, wrreq}, 32'h0);
      if (wrreq) begin
        check($sformatf("write_index_bound_%0d", wcnt), {31'b0, wcnt < FRAME}, 32'h1);
        bad = 0;
        for (int c = 7; c >= 0; c--) if (dout[c] !== exp_word(wcnt, c, W, H)) bad = c;
        check($sformatf("write%0d_lane%0d", wcnt, bad), dout[bad], exp_word(wcnt, bad, W, H));
        if (wcnt < FRAME) wlog[wcnt] = dout[0];
        wcnt++;
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (v && ready) acc++;
      if (ready) rdy_cnt++;
      if (fd) begin
        fd_cnt++;
        last_writes = wcnt;
        wcnt = 0;
        acc = 0;
      end
    end
    cyc++;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rdy_cnt = 0; fd_cnt = 0; last_writes = 0;
    first_wr = -1; last_wr = -1; cyc = 0;
  endtask

  task automatic run_frame(input int bubble_pct);
    logic v;
    clear_stats();
    for (int i = 0; i < 400 && fd_cnt == 0; i++) begin
      v = (bubble_pct == 0) ? 1'b1 : ($urandom_range(1, 100) > bubble_pct);
      tick(v, 8'h00, 1'b0);
    end
    check("frame_done_seen", {31'b0, fd_cnt == 1}, 32'h1);
    tick(1'b0, 8'h00, 1'b0);
    check("frame_done_single_pulse", fd_cnt, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    logic [31:0] orv;
    orv = 32'h0;
    for (int c = 0; c < 8; c++) orv = orv | dout[c];
    check({name, "_wrreq"}, {31'b0, s_wr}, 32'h0);
    check({name, "_ready"}, {31'b0, s_rdy}, 32'h0);
    check({name, "_frame_done"}, {31'b0, s_fd}, 32'h0);
    check({name, "_data"}, orv, 32'h0);
  endtask

  initial begin
    int bw, bacc, berr;
    for (int c = 0; c < 8; c++) begin
      din[c] = 32'h0;
      b_din[c] = 32'h0;
    end

    // valid, full, exp wrreq, exp ready, exp frame_done, exp lane-0 data
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0};         // idle, nothing pending
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0};         // idle -> run, not consumed
    tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,0)
    tbl[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,1)
    tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0};         // (0,2) full
    tbl[5]  = '{1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 32'h0};         // (0,2) full
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,2) deferred pad
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,3)
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,4)
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (0,5)
    tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};         // (1,0)
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h01000001};  // (1,1) bubble
    tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'h01000001};  // (1,1) pixel 0
    tbl[13] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 32'h01000002};  // (1,2) full wins
    tbl[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'h01000002};  // (1,2) pixel 1

    // Reset state
    clear_stats();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check_idle_outputs("reset");

    // Back-to-back frame, valid held high
    run_frame(0);
    check("s1_writes", wr_cnt, FRAME);
    check("s1_consecutive", last_wr - first_wr + 1, FRAME);
    check("s1_ready_cycles", rdy_cnt, W * H);
    check("s1_write0_zero", wlog[0], 32'h0);
    check("s1_write6_zero", wlog[6], 32'h0);
    check("s1_write7_pix0", wlog[7], 32'h01000001);
    check("s1_last_write_zero", wlog[FRAME-1], 32'h0);

    // Random bubbles
    run_frame(50);
    check("s2_writes", last_writes, FRAME);
    check("s2_ready_accepts_all", {31'b0, rdy_cnt >= W * H}, 32'h1);

    // Table: full on pad (0,2) and on interior (1,2)
    clear_stats();
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].v, tbl[i].f, 1'b0);
      check($sformatf("tbl%0d_wrreq", i), {31'b0, s_wr}, {31'b0, tbl[i].e_wr});
      check($sformatf("tbl%0d_ready", i), {31'b0, s_rdy}, {31'b0, tbl[i].e_rdy});
      check($sformatf("tbl%0d_frame_done", i), {31'b0, s_fd}, {31'b0, tbl[i].e_fd});
      check($sformatf("tbl%0d_data0", i), dout[0], tbl[i].e_d0);
    end
    check("tbl_position", wcnt, 32'd9);

    // Full on channel 5 for 3 cycles in interior row 2
    for (int i = 0; i < 50 && wcnt < 14; i++) tick(1'b1, 8'h00, 1'b0);
    check("row2_reached", wcnt, 32'd14);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h20, 1'b0);
      check($sformatf("row2_full%0d_wrreq", i), {31'b0, s_wr}, 32'h0);
      check($sformatf("row2_full%0d_ready", i), {31'b0, s_rdy}, 32'h0);
    end
    tick(1'b1, 8'h00, 1'b0);
    check("row2_resume_wrreq", {31'b0, s_wr}, 32'h1);
    for (int i = 0; i < 100 && fd_cnt == 0; i++) tick(1'b1, 8'h00, 1'b0);
    check("row2_frame_writes", last_writes, FRAME);
    tick(1'b0, 8'h00, 1'b0);

    // Reset after write 15
    for (int i = 0; i < 100 && wcnt < 16; i++) tick(1'b1, 8'h00, 1'b0);
    check("rst_reached_16", wcnt, 32'd16);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check_idle_outputs("mid_rst");
    run_frame(0);
    check("post_rst_writes", wr_cnt, FRAME);

    // Default 112x112 frame, per-channel distinct data
    @(posedge clk); #1 b_rst = 1'b1;
    @(posedge clk); #1 b_rst = 1'b0;
    bw = 0; bacc = 0; berr = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      b_valid = 1'b1;
      for (int c = 0; c < 8; c++) b_din[c] = pix(bacc, c);
      @(negedge clk);
      if (b_wr) begin
        for (int c = 0; c < 8; c++) if (b_dout[c] !== exp_word(bw, c, 112, 112)) berr++;
        bw++;
      end
      if (b_valid && b_rdy) bacc++;
      if (b_fd) break;
    end
    check("big_writes", bw, 32'd12996);
    check("big_accepts", bacc, 32'd12544);
    check("big_lane_errors", berr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
